// File: rtl/exec_mem_pkg.sv
// Shared definitions for the accumulator CPU execute/memory stage:
// opcodes, FSM states, ALU operation codes and SKIP condition codes.
package exec_mem_pkg;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_CLEAR = 4'h5;
    localparam logic [3:0] OP_SKIP  = 4'h6;
    localparam logic [3:0] OP_JUMP  = 4'h7;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_NOT   = 4'hA;
    localparam logic [3:0] OP_JNS   = 4'hB;
    localparam logic [3:0] OP_JUMPI = 4'hC;
    localparam logic [3:0] OP_NOP   = 4'hF;

    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_CARRY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MEM_RD = 2'b01,
        ST_MEM_WR = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_NOT  = 3'd5,
        ALU_CLR  = 3'd6
    } alu_op_e;

    function automatic logic is_mem_rd(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_LOAD, OP_AND, OP_OR, OP_JUMPI: is_mem_rd = 1'b1;
            default:                                          is_mem_rd = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_wr(input logic [3:0] op);
        case (op)
            OP_STORE, OP_JNS: is_mem_wr = 1'b1;
            default:          is_mem_wr = 1'b0;
        endcase
    endfunction

    // LOAD reuses the ALU as a pass-through of the read data
    function automatic alu_op_e alu_sel(input logic [3:0] op);
        case (op)
            OP_ADD:   alu_sel = ALU_ADD;
            OP_SUB:   alu_sel = ALU_SUB;
            OP_AND:   alu_sel = ALU_AND;
            OP_OR:    alu_sel = ALU_OR;
            OP_NOT:   alu_sel = ALU_NOT;
            OP_CLEAR: alu_sel = ALU_CLR;
            default:  alu_sel = ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/exec_mem_alu.sv
// Combinational ALU for the execute/memory stage. Flag generation ({N,Z,C,V})
// exists only when EXEC_MEM_FLAGS_EN is defined; otherwise flags are zero.
module exec_mem_alu
    import exec_mem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    logic [DATA_W:0] add_ext_s;
    logic [DATA_W:0] sub_ext_s;

    assign add_ext_s = {1'b0, a} + {1'b0, b};
    assign sub_ext_s = {1'b0, a} - {1'b0, b};

    // Result selection
    always_comb begin
        result = a;
        case (alu_op_e'(op))
            ALU_PASS: result = b;
            ALU_ADD:  result = add_ext_s[DATA_W-1:0];
            ALU_SUB:  result = sub_ext_s[DATA_W-1:0];
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_NOT:  result = ~a;
            ALU_CLR:  result = {DATA_W{1'b0}};
            default:  result = a;
        endcase
    end

`ifdef EXEC_MEM_FLAGS_EN
    logic carry_s;
    logic ovf_s;

    // C is carry-out for ADD and no-borrow for SUB; every other AC write clears C and V
    always_comb begin
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD: begin
                carry_s = add_ext_s[DATA_W];
                ovf_s   = (a[DATA_W-1] == b[DATA_W-1]) && (add_ext_s[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                carry_s = ~sub_ext_s[DATA_W];
                ovf_s   = (a[DATA_W-1] != b[DATA_W-1]) && (sub_ext_s[DATA_W-1] != a[DATA_W-1]);
            end
            default: begin
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    assign flags = {result[DATA_W-1], (result == {DATA_W{1'b0}}), carry_s, ovf_s};
`else
    logic unused_carry_s;

    assign unused_carry_s = add_ext_s[DATA_W] ^ sub_ext_s[DATA_W];
    assign flags          = 4'b0000;
`endif

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory stage of the accumulator CPU: runs one decoded instruction per
// handshake against AC and a req/ack data memory. Optional flags: EXEC_MEM_FLAGS_EN.
module exec_mem_unit
    import exec_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [ADDR_W-1:0] in_operand,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ac,
    output logic              pc_wr_en,
    output logic [ADDR_W-1:0] pc_wr_data,
    output logic              retire,
    output logic              halted,
    output logic [3:0]        flags
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_TWO = {{(ADDR_W-2){1'b0}}, 2'b10};

    state_e            state_r, state_nxt_s;
    logic [3:0]        op_r, op_nxt_s, dec_op_s;
    logic [ADDR_W-1:0] operand_r, operand_nxt_s;
    logic [DATA_W-1:0] ac_r, ac_nxt_s;
    logic [3:0]        flags_r, flags_nxt_s;
    logic              mem_req_r, mem_req_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic              pc_wr_en_r, pc_wr_en_nxt_s;
    logic [ADDR_W-1:0] pc_wr_data_r, pc_wr_data_nxt_s;
    logic              retire_r, retire_nxt_s;
    logic              halted_r, halted_nxt_s;
    logic              ready_s, accept_s, skip_s;
    alu_op_e           alu_op_s;
    logic [DATA_W-1:0] alu_res_s;
    logic [3:0]        alu_flags_s;

    // Opcodes wider than the defined set, or unassigned codes, collapse to NOP
    function automatic logic [3:0] decode_op(input logic [OP_W-1:0] opc);
        logic [OP_W-1:0] hi;
        hi = opc >> 3'd4;
        if (hi != {OP_W{1'b0}}) begin
            decode_op = OP_NOP;
        end else if (opc[3:0] > OP_JUMPI) begin
            decode_op = OP_NOP;
        end else begin
            decode_op = opc[3:0];
        end
    endfunction

    assign dec_op_s = decode_op(in_opcode);
    assign ready_s  = (state_r == ST_IDLE) && !halted_r && !rst;
    assign accept_s = in_valid && ready_s;

    // ALU works on the incoming op in IDLE and on the latched op while waiting for memory
    always_comb begin
        if (state_r == ST_IDLE) begin
            alu_op_s = alu_sel(dec_op_s);
        end else begin
            alu_op_s = alu_sel(op_r);
        end
    end

    exec_mem_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (alu_op_s),
        .a      (ac_r),
        .b      (mem_rdata),
        .result (alu_res_s),
        .flags  (alu_flags_s)
    );

    // SKIP condition evaluation against the current AC
    always_comb begin
        case (in_operand[1:0])
            SKIP_NEG:   skip_s = ac_r[DATA_W-1];
            SKIP_ZERO:  skip_s = (ac_r == {DATA_W{1'b0}});
            SKIP_POS:   skip_s = !ac_r[DATA_W-1] && (ac_r != {DATA_W{1'b0}});
`ifdef EXEC_MEM_FLAGS_EN
            SKIP_CARRY: skip_s = flags_r[1];
`else
            SKIP_CARRY: skip_s = 1'b0;
`endif
            default:    skip_s = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (dec_op_s == OP_HALT) begin
                    state_nxt_s = ST_HALTED;
                end else if (is_mem_rd(dec_op_s)) begin
                    state_nxt_s = ST_MEM_RD;
                end else if (is_mem_wr(dec_op_s)) begin
                    state_nxt_s = ST_MEM_WR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (mem_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the datapath and output registers
    always_comb begin
        op_nxt_s         = op_r;
        operand_nxt_s    = operand_r;
        ac_nxt_s         = ac_r;
        flags_nxt_s      = flags_r;
        mem_req_nxt_s    = mem_req_r;
        mem_we_nxt_s     = mem_we_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        pc_wr_en_nxt_s   = 1'b0;
        pc_wr_data_nxt_s = pc_wr_data_r;
        retire_nxt_s     = 1'b0;
        halted_nxt_s     = halted_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    op_nxt_s = op_r;
                end else if (is_mem_rd(dec_op_s)) begin
                    op_nxt_s       = dec_op_s;
                    operand_nxt_s  = in_operand;
                    mem_req_nxt_s  = 1'b1;
                    mem_we_nxt_s   = 1'b0;
                    mem_addr_nxt_s = in_operand;
                end else if (is_mem_wr(dec_op_s)) begin
                    op_nxt_s       = dec_op_s;
                    operand_nxt_s  = in_operand;
                    mem_req_nxt_s  = 1'b1;
                    mem_we_nxt_s   = 1'b1;
                    mem_addr_nxt_s = in_operand;
                    if (dec_op_s == OP_JNS) begin
                        mem_wdata_nxt_s = DATA_W'(in_pc + ADDR_ONE);
                    end else begin
                        mem_wdata_nxt_s = ac_r;
                    end
                end else begin
                    op_nxt_s      = dec_op_s;
                    operand_nxt_s = in_operand;
                    retire_nxt_s  = 1'b1;
                    case (dec_op_s)
                        OP_HALT: halted_nxt_s = 1'b1;
                        OP_CLEAR, OP_NOT: begin
                            ac_nxt_s    = alu_res_s;
                            flags_nxt_s = alu_flags_s;
                        end
                        OP_SKIP: begin
                            pc_wr_en_nxt_s = skip_s;
                            if (skip_s) begin
                                pc_wr_data_nxt_s = in_pc + ADDR_TWO;
                            end else begin
                                pc_wr_data_nxt_s = pc_wr_data_r;
                            end
                        end
                        OP_JUMP: begin
                            pc_wr_en_nxt_s   = 1'b1;
                            pc_wr_data_nxt_s = in_operand;
                        end
                        default: retire_nxt_s = 1'b1;
                    endcase
                end
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (mem_ack) begin
                    mem_req_nxt_s = 1'b0;
                    retire_nxt_s  = 1'b1;
                    case (op_r)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: begin
                            ac_nxt_s    = alu_res_s;
                            flags_nxt_s = alu_flags_s;
                        end
                        OP_JUMPI: begin
                            pc_wr_en_nxt_s   = 1'b1;
                            pc_wr_data_nxt_s = mem_rdata[ADDR_W-1:0];
                        end
                        OP_JNS: begin
                            pc_wr_en_nxt_s   = 1'b1;
                            pc_wr_data_nxt_s = operand_r + ADDR_ONE;
                        end
                        default: retire_nxt_s = 1'b1;
                    endcase
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            ST_HALTED: halted_nxt_s = 1'b1;
            default:   retire_nxt_s = 1'b0;
        endcase
    end

    // Datapath and output registers; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r         <= OP_NOP;
            operand_r    <= {ADDR_W{1'b0}};
            ac_r         <= {DATA_W{1'b0}};
            flags_r      <= 4'b0000;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            pc_wr_en_r   <= 1'b0;
            pc_wr_data_r <= {ADDR_W{1'b0}};
            retire_r     <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            op_r         <= op_nxt_s;
            operand_r    <= operand_nxt_s;
            ac_r         <= ac_nxt_s;
            flags_r      <= flags_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            pc_wr_en_r   <= pc_wr_en_nxt_s;
            pc_wr_data_r <= pc_wr_data_nxt_s;
            retire_r     <= retire_nxt_s;
            halted_r     <= halted_nxt_s;
        end
    end

    assign in_ready   = ready_s;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign ac         = ac_r;
    assign pc_wr_en   = pc_wr_en_r;
    assign pc_wr_data = pc_wr_data_r;
    assign retire     = retire_r;
    assign halted     = halted_r;
    assign flags      = flags_r;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit; flag expectations follow
// whether EXEC_MEM_FLAGS_EN is defined for the build.
module tb_exec_mem_unit;

`ifdef EXEC_MEM_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_opcode = 8'h00;
    logic [15:0] in_operand = 16'h0000;
    logic [15:0] in_pc = 16'h0000;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] ac;
    logic        pc_wr_en;
    logic [15:0] pc_wr_data;
    logic        retire, halted;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_mem_unit #(.DATA_W(16), .ADDR_W(16), .OP_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_operand(in_operand), .in_pc(in_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ac(ac), .pc_wr_en(pc_wr_en),
        .pc_wr_data(pc_wr_data), .retire(retire), .halted(halted), .flags(flags)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic [7:0] op, input logic [15:0] opd, input logic [15:0] pc);
        @(negedge clk);
        in_valid = 1'b1; in_opcode = op; in_operand = opd; in_pc = pc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Memory responder: acks after 'waits' idle cycles, reports the request it saw
    task automatic serve_mem(input int waits, input logic [15:0] rdata,
                             output logic [15:0] addr, output logic we,
                             output logic [15:0] wdata, output int req_cycles);
        req_cycles = 0; addr = 16'h0000; we = 1'b0; wdata = 16'h0000;
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            if (k == 0) begin addr = mem_addr; we = mem_we; wdata = mem_wdata; end
            if (mem_req === 1'b1) req_cycles++;
            mem_ack = (k == waits); mem_rdata = rdata;
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({in_ready, mem_req, retire, halted, pc_wr_en} !== 5'b00000) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, mem_req, retire, halted, pc_wr_en}); end
        checks++; if ({ac, flags} !== 20'h00000) begin errors++; $display("FAIL reset_ac_flags: got %h want 00000", {ac, flags}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_load_wait();
        logic [15:0] a, wd; logic we; int rc;
        issue(8'h03, 16'h0010, 16'h0000);
        serve_mem(2, 16'h1234, a, we, wd, rc);
        checks++; if (rc !== 3) begin errors++; $display("FAIL load_req_cycles: got %0d want 3", rc); end
        checks++; if ({a, we} !== {16'h0010, 1'b0}) begin errors++; $display("FAIL load_req: got %h/%b want 0010/0", a, we); end
        checks++; if ({mem_req, retire, in_ready} !== 3'b011) begin errors++; $display("FAIL load_retire: got %b want 011", {mem_req, retire, in_ready}); end
        checks++; if (ac !== 16'h1234) begin errors++; $display("FAIL load_ac: got %h want 1234", ac); end
        @(negedge clk);
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL load_retire_pulse: got %b want 0", retire); end
    endtask

    task automatic test_add_skip();
        logic [15:0] a, wd; logic we; int rc;
        issue(8'h03, 16'h0011, 16'h0001);
        serve_mem(0, 16'h7FFF, a, we, wd, rc);
        issue(8'h01, 16'h0012, 16'h0002);
        serve_mem(0, 16'h0001, a, we, wd, rc);
        checks++; if (rc !== 1) begin errors++; $display("FAIL add_req_cycles: got %0d want 1", rc); end
        checks++; if (ac !== 16'h8000) begin errors++; $display("FAIL add_ac: got %h want 8000", ac); end
        checks++; if (flags !== (FLAGS_ON ? 4'b1001 : 4'b0000)) begin errors++; $display("FAIL add_flags: got %b want %b", flags, FLAGS_ON ? 4'b1001 : 4'b0000); end
        issue(8'h06, 16'h0000, 16'h0020);
        @(negedge clk);
        checks++; if ({retire, pc_wr_en, pc_wr_data} !== {2'b11, 16'h0022}) begin errors++; $display("FAIL skip_neg: got %b%b %h want 11 0022", retire, pc_wr_en, pc_wr_data); end
        issue(8'h06, 16'h0001, 16'h0030);
        @(negedge clk);
        checks++; if ({retire, pc_wr_en} !== 2'b10) begin errors++; $display("FAIL skip_zero_false: got %b want 10", {retire, pc_wr_en}); end
    endtask

    task automatic test_logic_sub();
        logic [15:0] a, wd; logic we; int rc;
        // CLEAR and NOT issued back to back with in_valid held
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 8'h05; in_operand = 16'h0000; in_pc = 16'h0050;
        @(posedge clk);
        #1 in_opcode = 8'h0A; in_pc = 16'h0051;
        @(negedge clk);
        checks++; if ({retire, in_ready, ac} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL b2b_clear: got %b%b %h want 11 0000", retire, in_ready, ac); end
        checks++; if (flags !== (FLAGS_ON ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL clear_flags: got %b", flags); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if ({retire, ac} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL b2b_not: got %b %h want 1 FFFF", retire, ac); end
        issue(8'h08, 16'h0013, 16'h0052);
        serve_mem(1, 16'h0F0F, a, we, wd, rc);
        checks++; if (ac !== 16'h0F0F) begin errors++; $display("FAIL and_ac: got %h want 0F0F", ac); end
        issue(8'h09, 16'h0014, 16'h0053);
        serve_mem(0, 16'hF000, a, we, wd, rc);
        checks++; if (ac !== 16'hFF0F) begin errors++; $display("FAIL or_ac: got %h want FF0F", ac); end
        issue(8'h02, 16'h0015, 16'h0054);
        serve_mem(0, 16'hFF10, a, we, wd, rc);
        checks++; if ({ac, flags} !== {16'hFFFF, FLAGS_ON ? 4'b1000 : 4'b0000}) begin errors++; $display("FAIL sub_borrow: got %h %b", ac, flags); end
        issue(8'h02, 16'h0016, 16'h0055);
        serve_mem(0, 16'h000F, a, we, wd, rc);
        checks++; if ({ac, flags} !== {16'hFFF0, FLAGS_ON ? 4'b1010 : 4'b0000}) begin errors++; $display("FAIL sub_noborrow: got %h %b", ac, flags); end
        issue(8'h06, 16'h0003, 16'h0040);
        @(negedge clk);
        checks++; if ({retire, pc_wr_en} !== {1'b1, FLAGS_ON}) begin errors++; $display("FAIL skip_carry: got %b want 1%b", {retire, pc_wr_en}, FLAGS_ON); end
        issue(8'h06, 16'h0000, 16'hFFFF);
        @(negedge clk);
        checks++; if ({pc_wr_en, pc_wr_data} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL skip_wrap: got %b %h want 1 0001", pc_wr_en, pc_wr_data); end
        issue(8'h55, 16'h0000, 16'h0060);
        @(negedge clk);
        checks++; if ({retire, pc_wr_en, mem_req, ac} !== {3'b100, 16'hFFF0}) begin errors++; $display("FAIL nop: got %b%b%b %h want 100 FFF0", retire, pc_wr_en, mem_req, ac); end
    endtask

    task automatic test_control();
        logic [15:0] a, wd; logic we; int rc;
        issue(8'h0B, 16'h0040, 16'h0100);
        serve_mem(0, 16'h0000, a, we, wd, rc);
        checks++; if ({a, we, wd} !== {16'h0040, 1'b1, 16'h0101}) begin errors++; $display("FAIL jns_write: got %h %b %h want 0040 1 0101", a, we, wd); end
        checks++; if ({retire, pc_wr_en, pc_wr_data} !== {2'b11, 16'h0041}) begin errors++; $display("FAIL jns_pc: got %b%b %h want 11 0041", retire, pc_wr_en, pc_wr_data); end
        issue(8'h0C, 16'h0040, 16'h0102);
        serve_mem(1, 16'h0101, a, we, wd, rc);
        checks++; if ({a, we, rc} !== {16'h0040, 1'b0, 32'd2}) begin errors++; $display("FAIL jumpi_read: got %h %b %0d want 0040 0 2", a, we, rc); end
        checks++; if ({pc_wr_en, pc_wr_data} !== {1'b1, 16'h0101}) begin errors++; $display("FAIL jumpi_pc: got %b %h want 1 0101", pc_wr_en, pc_wr_data); end
        issue(8'h07, 16'h0123, 16'h0103);
        @(negedge clk);
        checks++; if ({retire, pc_wr_en, pc_wr_data} !== {2'b11, 16'h0123}) begin errors++; $display("FAIL jump_pc: got %b%b %h want 11 0123", retire, pc_wr_en, pc_wr_data); end
    endtask

    task automatic test_store_reset();
        issue(8'h04, 16'h0050, 16'h0200);
        repeat (3) @(negedge clk);
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0050, 16'hFFF0}) begin errors++; $display("FAIL store_hold: got %b%b %h %h want 11 0050 FFF0", mem_req, mem_we, mem_addr, mem_wdata); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req, ac, in_ready} !== {1'b0, 16'h0000, 1'b1}) begin errors++; $display("FAIL store_reset: got %b %h %b want 0 0000 1", mem_req, ac, in_ready); end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        checks++; if ({retire, mem_req, pc_wr_en, ac} !== {3'b000, 16'h0000}) begin errors++; $display("FAIL late_ack: got %b%b%b %h want 000 0000", retire, mem_req, pc_wr_en, ac); end
    endtask

    task automatic test_halt();
        int bad;
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 8'h00; in_operand = 16'h0000; in_pc = 16'h0300;
        @(posedge clk);
        #1 in_opcode = 8'h03; in_operand = 16'h0010;
        @(negedge clk);
        checks++; if ({retire, halted, in_ready} !== 3'b110) begin errors++; $display("FAIL halt_enter: got %b want 110", {retire, halted, in_ready}); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({mem_req, in_ready, halted, retire} !== 4'b0010) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL halt_sticky: got %0d bad cycles want 0", bad); end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({halted, in_ready} !== 2'b01) begin errors++; $display("FAIL halt_release: got %b want 01", {halted, in_ready}); end
    endtask

    initial begin
        test_reset();
        test_load_wait();
        test_add_skip();
        test_logic_sub();
        test_control();
        test_store_reset();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
